// File: rtl/ser_sample_loader.sv
// Serial-to-parallel sample loader: assembles LSB-first 16-bit words and writes them at p*(feat+1)+w.
// Write strobe one cycle after a word's 16th valid bit; no back-pressure, S_VALID gaps simply stall assembly.
module ser_sample_loader #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [3:0]        feat,
  input  logic [11:0]       data_points,
  input  logic              S,
  input  logic              S_VALID,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [WORD_W-1:0] WR_DATA,
  output logic              BUSY,
  output logic              LOAD_DONE
);

  localparam int BCNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [3:0]        feat_q,    feat_d;
  logic [11:0]       dp_q,      dp_d;
  logic [BCNT_W-1:0] bcnt_q,    bcnt_d;
  logic [3:0]        widx_q,    widx_d;
  logic [ADDR_W-1:0] base_q,    base_d;
  logic [11:0]       pcnt_q,    pcnt_d;
  logic [WORD_W-1:0] shreg_q,   shreg_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;

  logic [WORD_W-1:0] word_in;

  assign word_in = {S, shreg_q[WORD_W-1:1]};

  always_comb begin
    state_d   = state_q;
    feat_d    = feat_q;
    dp_d      = dp_q;
    bcnt_d    = bcnt_q;
    widx_d    = widx_q;
    base_d    = base_q;
    pcnt_d    = pcnt_q;
    shreg_d   = shreg_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Bits arriving on the START edge are dropped; reception begins on the next edge.
        if (START) begin
          feat_d  = feat;
          dp_d    = data_points;
          bcnt_d  = '0;
          shreg_d = '0;
          widx_d  = feat;
          base_d  = '0;
          pcnt_d  = '0;
          state_d = (data_points == 12'd0) ? ST_DONE : ST_RECV;
        end
      end

      ST_RECV: begin
        if (S_VALID) begin
          shreg_d = word_in;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_LAST) begin
            bcnt_d    = '0;
            wr_en_d   = 1'b1;
            wr_data_d = word_in;
            wr_addr_d = base_q + ADDR_W'(widx_q);
            // Words within a sample arrive highest index first, so index 0 closes the sample.
            if (widx_q == 4'd0) begin
              widx_d = feat_q;
              base_d = base_q + ADDR_W'(feat_q) + ADDR_W'(1);
              pcnt_d = pcnt_q + 12'd1;
              if (pcnt_q == dp_q - 12'd1) begin
                state_d = ST_DONE;
              end
            end else begin
              widx_d = widx_q - 4'd1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      feat_q    <= '0;
      dp_q      <= '0;
      bcnt_q    <= '0;
      widx_q    <= '0;
      base_q    <= '0;
      pcnt_q    <= '0;
      shreg_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      feat_q    <= feat_d;
      dp_q      <= dp_d;
      bcnt_q    <= bcnt_d;
      widx_q    <= widx_d;
      base_q    <= base_d;
      pcnt_q    <= pcnt_d;
      shreg_q   <= shreg_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign BUSY      = (state_q == ST_RECV);
  assign LOAD_DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_ser_sample_loader.sv
// Directed bench for ser_sample_loader: drives serial streams and checks the recorded write sequence.
module tb_ser_sample_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [3:0]  feat = '0;
  logic [11:0] data_points = '0;
  logic        S = 1'b0;
  logic        S_VALID = 1'b0;
  logic        WR_EN;
  logic [15:0] WR_ADDR;
  logic [15:0] WR_DATA;
  logic        BUSY;
  logic        LOAD_DONE;

  int checks = 0;
  int failures = 0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  logic        wl[$];

  ser_sample_loader #(.WORD_W(16), .ADDR_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .feat(feat), .data_points(data_points),
    .S(S), .S_VALID(S_VALID), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .BUSY(BUSY), .LOAD_DONE(LOAD_DONE)
  );

  always #5 CLK = ~CLK;

  // Write recorder, sampled 1ns after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (WR_EN === 1'b1) begin
      wa.push_back(WR_ADDR);
      wd.push_back(WR_DATA);
      wl.push_back(LOAD_DONE);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] word_val(input int p, input int w, input int seed);
    logic [15:0] v;
    v = 16'(p * 961 + w * 4369 + seed * 7919) ^ 16'hA5C3;
    return v;
  endfunction

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wl.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // START pulse with a valid '1' bit on the same edge, which must not be consumed.
  task automatic pulse_start(input int f, input int dp);
    START = 1'b1;
    feat = 4'(f);
    data_points = 12'(dp);
    S = 1'b1;
    S_VALID = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    S_VALID = 1'b0;
    feat = 4'($urandom);
    data_points = 12'($urandom);
  endtask

  task automatic send_bit(input logic b, input int gap_max, input bit mid_start);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
    repeat (g) begin
      S_VALID = 1'b0;
      S = 1'($urandom);
      @(negedge CLK);
    end
    S = b;
    S_VALID = 1'b1;
    if (mid_start) begin
      START = 1'b1;
      feat = 4'd3;
      data_points = 12'd7;
    end
    @(negedge CLK);
    S_VALID = 1'b0;
    START = 1'b0;
    feat = 4'($urandom);
    data_points = 12'($urandom);
  endtask

  // Streams dp samples of f+1 words; stops early after stop_bits bits when stop_bits >= 0.
  task automatic run_load(input string name, input int f, input int dp, input int seed,
                          input int gap_max, input int start_at_bit, input int stop_bits);
    int bitidx;
    int n;
    int p;
    int w;
    logic [15:0] v;
    logic [15:0] ea;
    logic [15:0] ed;
    logic        el;
    clear_log();
    pulse_start(f, dp);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_start: got %b want 1", name, BUSY);
    end
    bitidx = 0;
    for (int pp = 0; pp < dp; pp++) begin
      for (int ww = f; ww >= 0; ww--) begin
        v = word_val(pp, ww, seed);
        for (int b = 0; b < 16; b++) begin
          if (stop_bits >= 0 && bitidx == stop_bits) return;
          send_bit(v[b], gap_max, bitidx == start_at_bit);
          bitidx++;
        end
      end
    end
    @(negedge CLK);
    n = dp * (f + 1);
    checks++;
    if (wa.size() != n) begin
      failures++;
      $display("FAIL %s write_count: got %0d want %0d", name, wa.size(), n);
    end
    for (int k = 0; k < n && k < wa.size(); k++) begin
      p  = k / (f + 1);
      w  = f - (k % (f + 1));
      ea = 16'(p * (f + 1) + w);
      ed = word_val(p, w, seed);
      el = (k == n - 1);
      checks++;
      if (wa[k] !== ea || wd[k] !== ed || wl[k] !== el) begin
        failures++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%h done=%b want addr=%0d data=%h done=%b",
                 name, k, wa[k], wd[k], wl[k], ea, ed, el);
      end
    end
    checks++;
    if (LOAD_DONE !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL %s end_state: got done=%b busy=%b want done=1 busy=0", name, LOAD_DONE, BUSY);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (WR_EN !== 1'b0 || WR_ADDR !== 16'h0 || WR_DATA !== 16'h0 || BUSY !== 1'b0 || LOAD_DONE !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got en=%b addr=%h data=%h busy=%b done=%b want all 0",
               WR_EN, WR_ADDR, WR_DATA, BUSY, LOAD_DONE);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || LOAD_DONE !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", BUSY, LOAD_DONE);
    end
  endtask

  task automatic test_lsb_first();
    logic [15:0] v;
    v = 16'h8001;
    clear_log();
    pulse_start(0, 1);
    for (int b = 0; b < 16; b++) send_bit(v[b], 0, 1'b0);
    @(negedge CLK);
    checks++;
    if (wa.size() != 1) begin
      failures++;
      $display("FAIL lsb_first_count: got %0d want 1", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 16'd0 || wd[0] !== 16'h8001 || wl[0] !== 1'b1) begin
        failures++;
        $display("FAIL lsb_first_write: got addr=%0d data=%h done=%b want addr=0 data=8001 done=1",
                 wa[0], wd[0], wl[0]);
      end
    end
  endtask

  task automatic test_full_set();
    run_load("full_set", 11, 4, 1, 0, -1, -1);
  endtask

  task automatic test_stall();
    run_load("stall", 11, 4, 1, 7, -1, -1);
  endtask

  task automatic test_zero_points();
    do_reset();
    clear_log();
    pulse_start(5, 0);
    checks++;
    if (LOAD_DONE !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL zero_points_done: got done=%b busy=%b want done=1 busy=0", LOAD_DONE, BUSY);
    end
    for (int i = 0; i < 20; i++) send_bit(1'($urandom), 0, 1'b0);
    checks++;
    if (wa.size() != 0) begin
      failures++;
      $display("FAIL zero_points_writes: got %0d want 0", wa.size());
    end
  endtask

  task automatic test_mid_start();
    run_load("mid_start", 11, 4, 3, 0, 300, -1);
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] ed;
    ed = word_val(0, 0, 5);
    run_load("reset_mid", 11, 4, 5, 0, -1, 200);
    checks++;
    if (wa.size() != 12 || WR_DATA !== ed) begin
      failures++;
      $display("FAIL reset_mid_prefix: got writes=%0d data=%h want writes=12 data=%h", wa.size(), WR_DATA, ed);
    end
    S = 1'b1;
    S_VALID = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (WR_EN !== 1'b0 || WR_ADDR !== 16'h0 || WR_DATA !== 16'h0 || BUSY !== 1'b0 || LOAD_DONE !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got en=%b addr=%h data=%h busy=%b done=%b want all 0",
               WR_EN, WR_ADDR, WR_DATA, BUSY, LOAD_DONE);
    end
    clear_log();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    S_VALID = 1'b0;
    checks++;
    if (wa.size() != 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abandon: got writes=%0d busy=%b want 0 0", wa.size(), BUSY);
    end
    run_load("after_reset", 11, 4, 9, 0, -1, -1);
  endtask

  task automatic test_reload();
    clear_log();
    for (int i = 0; i < 32; i++) send_bit(1'($urandom), 0, 1'b0);
    checks++;
    if (wa.size() != 0 || LOAD_DONE !== 1'b1) begin
      failures++;
      $display("FAIL done_ignores_bits: got writes=%0d done=%b want 0 1", wa.size(), LOAD_DONE);
    end
    run_load("reload", 2, 3, 11, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_full_set();
    test_stall();
    test_zero_points();
    test_mid_start();
    test_reset_mid_load();
    test_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
